// File: rtl/sparc_mul_req.sv
// Purpose : EXU-side requester for the shared multiplier. It formats MULX/UMUL/SMUL operands,
//           drives the valid/ack handshake, waits the fixed latency and returns the product.
// Latency : start in cycle S with ack in S+1 gives the result strobe in S+2+MUL_LAT.
//           Minimum start-to-start spacing is MUL_LAT+3 cycles.
// Backpr. : mul_ecl_rdy=1 only in IDLE. The request is held with stable operands until
//           mul_exu_ack is seen.
// Ports   : rclk/rst (async, active-high)
//           ecl_mul_* : command, operands and kill from the EXU
//           exu_mul_* : request to the multiplier; mul_exu_ack and mul_data_out come back
//           mul_ecl_* : ready, result strobe, product, Y update and ack-timeout error
// Option  : define SPARC_MUL_REQ_ACK_TIMEOUT_EN to abandon a request that gets no ack in
//           63 REQ cycles. The abandoned request sets the sticky mul_ecl_ack_err.
module sparc_mul_req #(
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = 3
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        ecl_mul_start,
    input  logic [1:0]  ecl_mul_op,
    input  logic [63:0] ecl_mul_rs1,
    input  logic [63:0] ecl_mul_rs2,
    input  logic        ecl_mul_kill,
    output logic        mul_ecl_rdy,
    output logic        exu_mul_input_vld,
    output logic [63:0] exu_mul_rs1_data,
    output logic [63:0] exu_mul_rs2_data,
    input  logic        mul_exu_ack,
    input  logic [63:0] mul_data_out,
    output logic        mul_ecl_res_vld,
    output logic [63:0] mul_ecl_res,
    output logic        mul_ecl_y_wen,
    output logic [31:0] mul_ecl_y_data,
    output logic        mul_ecl_ack_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic               kill_flag;
    logic [CNT_W-1:0]   cnt;
    logic               handshake;
    logic               to_expire;
    logic               is_32b_mul;

    // UMUL zero-extends and SMUL sign-extends the low word. MULX and the reserved
    // encoding pass the raw value. Only the low 64 bits of the product are used,
    // so sign-extended operands need no later correction for SMUL.
    function automatic logic [63:0] fmt_operand(input logic [1:0] op, input logic [63:0] rs);
        logic [63:0] r;
        case (op)
            2'b01:   r = {32'b0, rs[31:0]};
            2'b10:   r = {{32{rs[31]}}, rs[31:0]};
            default: r = rs;
        endcase
        return r;
    endfunction

    assign handshake   = (state == REQ) & exu_mul_input_vld & mul_exu_ack;
    assign mul_ecl_rdy = (state == IDLE);
    assign is_32b_mul  = (op_q == 2'b01) | (op_q == 2'b10);

    // A kill can still arrive in the RESP cycle itself, so the live kill also qualifies the strobe.
    assign mul_ecl_res_vld = (state == RESP) & ~kill_flag & ~ecl_mul_kill;
    assign mul_ecl_y_wen   = mul_ecl_res_vld & is_32b_mul;

`ifdef SPARC_MUL_REQ_ACK_TIMEOUT_EN
    logic [5:0] to_cnt;

    // Holds 0 outside REQ, so it is cleared on every entry to REQ.
    // The value 62 marks the 63rd REQ cycle. An ack in that cycle still wins.
    assign to_expire = (state == REQ) & (to_cnt == 6'd62) & ~mul_exu_ack;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            to_cnt          <= 6'd0;
            mul_ecl_ack_err <= 1'b0;
        end else begin
            to_cnt <= (state == REQ) ? to_cnt + 6'd1 : 6'd0;
            if (to_expire)
                mul_ecl_ack_err <= 1'b1;
        end
    end
`else
    assign to_expire       = 1'b0;
    assign mul_ecl_ack_err = 1'b0;
`endif

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            op_q              <= 2'b00;
            kill_flag         <= 1'b0;
            cnt               <= '0;
            exu_mul_input_vld <= 1'b0;
            exu_mul_rs1_data  <= 64'd0;
            exu_mul_rs2_data  <= 64'd0;
            mul_ecl_res       <= 64'd0;
            mul_ecl_y_data    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A kill in IDLE refers to nothing in flight and is ignored.
                    if (ecl_mul_start) begin
                        op_q              <= ecl_mul_op;
                        exu_mul_rs1_data  <= fmt_operand(ecl_mul_op, ecl_mul_rs1);
                        exu_mul_rs2_data  <= fmt_operand(ecl_mul_op, ecl_mul_rs2);
                        exu_mul_input_vld <= 1'b1;
                        state             <= REQ;
                    end
                end
                REQ: begin
                    if (handshake) begin
                        // The multiplier has taken the operands, so a kill here only suppresses the result.
                        cnt               <= CNT_W'(MUL_LAT);
                        kill_flag         <= ecl_mul_kill;
                        exu_mul_input_vld <= 1'b0;
                        state             <= WAIT;
                    end else if (ecl_mul_kill | to_expire) begin
                        exu_mul_input_vld <= 1'b0;
                        state             <= IDLE;
                    end
                end
                WAIT: begin
                    // A killed multiply still waits the full latency so its product
                    // drains before any new request can be issued.
                    if (ecl_mul_kill)
                        kill_flag <= 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        mul_ecl_res    <= mul_data_out;
                        mul_ecl_y_data <= mul_data_out[63:32];
                        cnt            <= '0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    kill_flag <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparc_mul_req.sv
// Purpose : directed, table-driven bench for sparc_mul_req (MUL_LAT=5).
// Latency : the bench models the start -> REQ -> WAIT(MUL_LAT) -> RESP -> IDLE timing itself.
// Backpr. : ack is delayed per vector. Kill, reset and timeout cases are hand-written sequences.
module tb_sparc_mul_req;

    localparam int LAT = 5;
    localparam logic [63:0] JUNK = 64'hBADC0FFEE0DDF00D;

    logic        rclk;
    logic        rst;
    logic        ecl_mul_start;
    logic [1:0]  ecl_mul_op;
    logic [63:0] ecl_mul_rs1;
    logic [63:0] ecl_mul_rs2;
    logic        ecl_mul_kill;
    logic        mul_ecl_rdy;
    logic        exu_mul_input_vld;
    logic [63:0] exu_mul_rs1_data;
    logic [63:0] exu_mul_rs2_data;
    logic        mul_exu_ack;
    logic [63:0] mul_data_out;
    logic        mul_ecl_res_vld;
    logic [63:0] mul_ecl_res;
    logic        mul_ecl_y_wen;
    logic [31:0] mul_ecl_y_data;
    logic        mul_ecl_ack_err;

    int checks;
    int failures;

    sparc_mul_req #(.MUL_LAT(LAT), .CNT_W(3)) dut (
        .rclk              (rclk),
        .rst               (rst),
        .ecl_mul_start     (ecl_mul_start),
        .ecl_mul_op        (ecl_mul_op),
        .ecl_mul_rs1       (ecl_mul_rs1),
        .ecl_mul_rs2       (ecl_mul_rs2),
        .ecl_mul_kill      (ecl_mul_kill),
        .mul_ecl_rdy       (mul_ecl_rdy),
        .exu_mul_input_vld (exu_mul_input_vld),
        .exu_mul_rs1_data  (exu_mul_rs1_data),
        .exu_mul_rs2_data  (exu_mul_rs2_data),
        .mul_exu_ack       (mul_exu_ack),
        .mul_data_out      (mul_data_out),
        .mul_ecl_res_vld   (mul_ecl_res_vld),
        .mul_ecl_res       (mul_ecl_res),
        .mul_ecl_y_wen     (mul_ecl_y_wen),
        .mul_ecl_y_data    (mul_ecl_y_data),
        .mul_ecl_ack_err   (mul_ecl_ack_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        int          ack_dly;
        logic [63:0] prod;
        logic [63:0] exp_rs1;
        logic [63:0] exp_rs2;
        logic        exp_wen;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge rclk);
        #1;
    endtask

    // Runs one multiply starting in the current cycle and leaves the bench in the first
    // IDLE cycle after RESP. The next transaction therefore starts at minimum spacing.
    // kill_mode: 0 none, 1 kill in WAIT, 2 kill together with ack, 3 kill in the RESP cycle.
    task automatic do_txn(input vec_t v, input int kill_mode);
        logic exp_vld;
        exp_vld = (kill_mode == 0);
        // Cycle S: issue the start.
        ecl_mul_start = 1'b1;
        ecl_mul_op    = v.op;
        ecl_mul_rs1   = v.rs1;
        ecl_mul_rs2   = v.rs2;
        #2;
        chk("rdy_at_start", mul_ecl_rdy, 1'b1);
        nxt();
        ecl_mul_start = 1'b0;
        ecl_mul_rs1   = ~v.rs1;
        ecl_mul_rs2   = ~v.rs2;
        // REQ cycles: ack arrives ack_dly cycles after input_vld rises.
        for (int i = 0; i <= v.ack_dly; i++) begin
            mul_exu_ack  = (i == v.ack_dly);
            ecl_mul_kill = (i == v.ack_dly) && (kill_mode == 2);
            #2;
            chk("req_vld", exu_mul_input_vld, 1'b1);
            chk("req_rs1", exu_mul_rs1_data, v.exp_rs1);
            chk("req_rs2", exu_mul_rs2_data, v.exp_rs2);
            chk("req_rdy", mul_ecl_rdy, 1'b0);
            nxt();
        end
        mul_exu_ack  = 1'b0;
        ecl_mul_kill = 1'b0;
        // WAIT cycles: the product is valid only in the last one.
        for (int k = 1; k <= LAT; k++) begin
            mul_data_out = (k == LAT) ? v.prod : JUNK;
            ecl_mul_kill = (kill_mode == 1) && (k == 2);
            mul_exu_ack  = (kill_mode == 1) && (k == 3);
            #2;
            chk("wait_vld", exu_mul_input_vld, 1'b0);
            chk("wait_res_vld", mul_ecl_res_vld, 1'b0);
            chk("wait_rdy", mul_ecl_rdy, 1'b0);
            nxt();
        end
        mul_data_out = JUNK;
        mul_exu_ack  = 1'b0;
        ecl_mul_kill = (kill_mode == 3);
        // RESP cycle.
        #2;
        chk("resp_res_vld", mul_ecl_res_vld, exp_vld);
        chk("resp_y_wen", mul_ecl_y_wen, exp_vld & v.exp_wen);
        chk("resp_rdy", mul_ecl_rdy, 1'b0);
        chk("resp_res", mul_ecl_res, v.prod);
        chk("resp_y_data", mul_ecl_y_data, v.exp_y);
        nxt();
        ecl_mul_kill = 1'b0;
        // Idle bubble: the result is held and the block is ready again.
        #2;
        chk("idle_rdy", mul_ecl_rdy, 1'b1);
        chk("idle_res_vld", mul_ecl_res_vld, 1'b0);
        chk("idle_res_hold", mul_ecl_res, v.prod);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        ecl_mul_start = 1'b0;
        ecl_mul_op    = 2'b00;
        ecl_mul_rs1   = 64'd0;
        ecl_mul_rs2   = 64'd0;
        ecl_mul_kill  = 1'b0;
        mul_exu_ack   = 1'b0;
        mul_data_out  = JUNK;

        //                op     rs1                    rs2                    dly prod                   exp_rs1                exp_rs2                wen   exp_y
        vecs[0] = '{2'b00, 64'h0000000100000003, 64'h0000000000000005, 0, 64'h000000050000000F, 64'h0000000100000003, 64'h0000000000000005, 1'b0, 32'h00000005};
        vecs[1] = '{2'b10, 64'hDEADBEEFFFFFFFFE, 64'h1234567800000003, 0, 64'hFFFFFFFFFFFFFFFA, 64'hFFFFFFFFFFFFFFFE, 64'h0000000000000003, 1'b1, 32'hFFFFFFFF};
        vecs[2] = '{2'b01, 64'hFFFF000080000000, 64'h0000000000000002, 0, 64'h0000000100000000, 64'h0000000080000000, 64'h0000000000000002, 1'b1, 32'h00000001};
        vecs[3] = '{2'b01, 64'h1234567890ABCDEF, 64'hFFFFFFFF00000010, 3, 64'h000000090ABCDEF0, 64'h0000000090ABCDEF, 64'h0000000000000010, 1'b1, 32'h00000009};
        vecs[4] = '{2'b11, 64'h8000000000000001, 64'hFFFFFFFFFFFFFFFF, 1, 64'h7FFFFFFFFFFFFFFF, 64'h8000000000000001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'h7FFFFFFF};
        vecs[5] = '{2'b10, 64'hFFFFFFFF7FFFFFFF, 64'h0000000080000000, 2, 64'hC000000080000000, 64'h000000007FFFFFFF, 64'hFFFFFFFF80000000, 1'b1, 32'hC0000000};
        vecs[6] = '{2'b01, 64'h00000000FFFFFFFF, 64'hAAAAAAAAFFFFFFFF, 0, 64'hFFFFFFFE00000001, 64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 1'b1, 32'hFFFFFFFE};

        // Reset state.
        #2;
        chk("rst_rdy", mul_ecl_rdy, 1'b1);
        chk("rst_vld", exu_mul_input_vld, 1'b0);
        chk("rst_res_vld", mul_ecl_res_vld, 1'b0);
        chk("rst_res", mul_ecl_res, 64'd0);
        chk("rst_y_wen", mul_ecl_y_wen, 1'b0);
        chk("rst_ack_err", mul_ecl_ack_err, 1'b0);
        nxt();
        nxt();
        rst = 1'b0;

        // Table: back-to-back transactions at minimum spacing.
        for (int i = 0; i < 7; i++)
            do_txn(vecs[i], 0);

        // Kill in WAIT, kill together with ack, and kill in the RESP cycle.
        do_txn(vecs[1], 1);
        do_txn(vecs[2], 2);
        do_txn(vecs[3], 3);

        // A kill coincident with start is ignored. A later kill in REQ without ack aborts.
        ecl_mul_start = 1'b1;
        ecl_mul_kill  = 1'b1;
        ecl_mul_op    = 2'b00;
        ecl_mul_rs1   = 64'h1111;
        ecl_mul_rs2   = 64'h2222;
        nxt();
        ecl_mul_start = 1'b0;
        ecl_mul_kill  = 1'b0;
        #2;
        chk("kreq_vld_up", exu_mul_input_vld, 1'b1);
        nxt();
        ecl_mul_kill = 1'b1;
        #2;
        chk("kreq_vld_still", exu_mul_input_vld, 1'b1);
        nxt();
        ecl_mul_kill = 1'b0;
        #2;
        chk("kreq_vld_drop", exu_mul_input_vld, 1'b0);
        chk("kreq_rdy", mul_ecl_rdy, 1'b1);
        chk("kreq_res_vld", mul_ecl_res_vld, 1'b0);

        // Reset pulsed mid-WAIT takes effect immediately.
        ecl_mul_start = 1'b1;
        ecl_mul_op    = 2'b10;
        ecl_mul_rs1   = 64'h00000000FFFFFFF0;
        nxt();
        ecl_mul_start = 1'b0;
        mul_exu_ack   = 1'b1;
        nxt();
        mul_exu_ack = 1'b0;
        nxt();
        nxt();
        #2;
        chk("pre_rst_rdy", mul_ecl_rdy, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_rdy", mul_ecl_rdy, 1'b1);
        chk("arst_res", mul_ecl_res, 64'd0);
        chk("arst_y_data", mul_ecl_y_data, 32'd0);
        chk("arst_rs1", exu_mul_rs1_data, 64'd0);
        chk("arst_vld", exu_mul_input_vld, 1'b0);
        chk("arst_res_vld", mul_ecl_res_vld, 1'b0);
        nxt();
        rst = 1'b0;
        #2;
        do_txn(vecs[0], 0);

`ifdef SPARC_MUL_REQ_ACK_TIMEOUT_EN
        // Ack withheld: the request is abandoned after 63 REQ cycles.
        ecl_mul_start = 1'b1;
        ecl_mul_op    = 2'b00;
        nxt();
        ecl_mul_start = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            #2;
            chk("to_req_vld", exu_mul_input_vld, 1'b1);
            chk("to_err_low", mul_ecl_ack_err, 1'b0);
            nxt();
        end
        #2;
        chk("to_err", mul_ecl_ack_err, 1'b1);
        chk("to_vld", exu_mul_input_vld, 1'b0);
        chk("to_rdy", mul_ecl_rdy, 1'b1);
        chk("to_res_vld", mul_ecl_res_vld, 1'b0);
`else
        chk("ack_err_tied", mul_ecl_ack_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparc_mul_req.md
Name: sparc_mul_req

Overview:
- EXU-side initiator for the shared multiplier datapath.
- Accepts a multiply command from the EXU pipeline and formats the operands for MULX, UMUL or SMUL.
- Drives the operand/valid handshake into the multiplier and waits the fixed pipeline latency.
- Captures the 64-bit product and returns it to writeback, plus a Y-register update for 32-bit multiplies.

Parameters:
- MUL_LAT, 5: cycles from the accepted handshake (input_vld & ack edge) to a valid product on mul_data_out; legal range 1..7.
- CNT_W, 3: width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- rclk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ecl_mul_start  in  1  new multiply command; accepted only when mul_ecl_rdy=1
- ecl_mul_op  in  2  00 MULX, 01 UMUL, 10 SMUL, 11 reserved (treated as MULX)
- ecl_mul_rs1  in  64  raw operand 1
- ecl_mul_rs2  in  64  raw operand 2
- ecl_mul_kill  in  1  flush of the in-flight multiply
- mul_ecl_rdy  out  1  block idle, can accept a start
- exu_mul_input_vld  out  1  request to the multiplier, registered
- exu_mul_rs1_data  out  64  formatted operand 1, registered
- exu_mul_rs2_data  out  64  formatted operand 2, registered
- mul_exu_ack  in  1  multiplier accepts the request in this cycle
- mul_data_out  in  64  product from the multiplier
- mul_ecl_res_vld  out  1  one-cycle result strobe
- mul_ecl_res  out  64  product, registered
- mul_ecl_y_wen  out  1  Y write enable, coincident with res_vld
- mul_ecl_y_data  out  32  product[63:32]
- mul_ecl_ack_err  out  1  sticky ack-timeout flag

Behaviour:
- Reset (async, any state): FSM=IDLE; all registered outputs =0; kill flag =0; counter =0; mul_ecl_rdy=1.
- FSM states: IDLE, REQ, WAIT, RESP. mul_ecl_rdy = (state==IDLE).
- IDLE:
  - start=1: latch the formatted operands and op; state→REQ.
  - exu_mul_input_vld rises in the next cycle.
  - kill in IDLE is ignored, including when it coincides with start.
- Operand formatting:
  - MULX and op 11: operand = raw value.
  - UMUL: operand = {32'b0, rs[31:0]}.
  - SMUL: operand = {{32{rs[31]}}, rs[31:0]}.
  - Operands stay stable for the whole of REQ.
- REQ:
  - input_vld=1.
  - Handshake completes on an edge where input_vld & mul_exu_ack are both 1: counter←MUL_LAT, state→WAIT, input_vld←0.
  - kill without ack: state→IDLE, input_vld←0, no result.
  - kill together with ack: the handshake counts; state→WAIT with kill flag set.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter==1, mul_data_out is valid: register it into mul_ecl_res, and mul_ecl_y_data←mul_data_out[63:32]; state→RESP.
  - kill in WAIT sets the kill flag; the wait still runs to completion so no stale product is mistaken for a later one.
  - ack seen during WAIT is ignored.
- RESP (exactly 1 cycle, then →IDLE):
  - mul_ecl_res_vld = ~kill_flag & ~ecl_mul_kill.
  - mul_ecl_y_wen = same qualifier & (op==UMUL | op==SMUL).
  - Kill flag clears.
  - mul_ecl_res holds its value until the next capture.
- Timing:
  - Start in cycle S with ack in S+1 gives res_vld in cycle S+2+MUL_LAT.
  - Minimum start-to-start spacing = MUL_LAT+3, because of one IDLE bubble after RESP.
- Product width: the low 64 bits of the 64×64 product. Signedness is irrelevant for the low half with sign-extended operands, so SMUL needs no correction.

Optional Feature:
- Macro SPARC_MUL_REQ_ACK_TIMEOUT_EN.
- Defined:
  - A 6-bit counter runs in REQ and clears on entry to REQ.
  - If 63 cycles pass without ack: mul_ecl_ack_err←1 (sticky until rst), input_vld←0, state→IDLE, no result.
  - An ack in the 63rd cycle wins over the timeout.
- Undefined: REQ waits indefinitely; mul_ecl_ack_err tied 0.

Test Plan:
- MULX, immediate ack:
  - Stimulus: rs1=0x0000000100000003, rs2=0x5; ack in S+1; mul_data_out=0x000000050000000F in cycle S+1+MUL_LAT.
  - Response: res_vld=1 at S+7 (MUL_LAT=5), res=0x000000050000000F, y_wen=0.
- SMUL:
  - Stimulus: rs1=0xDEADBEEFFFFFFFFE, rs2=0x1234567800000003.
  - Response: operand outputs 0xFFFFFFFFFFFFFFFE / 0x0000000000000003.
  - Stimulus: product 0xFFFFFFFFFFFFFFFA.
  - Response: y_wen=1, y_data=0xFFFFFFFF.
- UMUL:
  - Stimulus: rs1=0xFFFF000080000000, rs2=0x2.
  - Response: operand 0x0000000080000000.
  - Stimulus: product 0x0000000100000000.
  - Response: y_data=0x00000001, y_wen=1.
- Delayed ack:
  - Stimulus: ack arrives 3 cycles after input_vld rises.
  - Response: input_vld and operands stable for all 3 cycles; res_vld exactly MUL_LAT+1 cycles after the ack edge; rdy=0 throughout.
- Kill:
  - Stimulus: kill in WAIT.
  - Response: no res_vld, no y_wen; rdy returns in the same cycle as the uncanceled case.
  - Stimulus: kill in REQ without ack.
  - Response: input_vld drops next cycle, rdy=1.
- Reset and timeout:
  - Stimulus: rst pulsed mid-WAIT.
  - Response: all outputs 0 immediately, rdy=1.
  - Stimulus (macro on): ack withheld.
  - Response: ack_err=1 after 63 REQ cycles, input_vld=0, rdy=1.
